// File: rtl/dff_share_pkg.sv
// Shared types and defaults for the shared-register arbiter family.
// rr_pick is the scalar reference form of the rotate-priority pick used by rr_picker.
package dff_share_pkg;

   localparam int unsigned N_REQ_DEF = 4;
   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned IDW_DEF   = $clog2(N_REQ_DEF);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic               found;
      logic [IDW_DEF-1:0] idx;
   } rr_pick_t;

   // Scans from the highest offset down so the lowest offset from ptr wins.
   function automatic rr_pick_t rr_pick(input logic [N_REQ_DEF-1:0] valid,
                                        input logic [IDW_DEF-1:0]   ptr);
      rr_pick_t           res;
      logic [IDW_DEF-1:0] k;
      res = '0;
      k   = '0;
      for (int i = int'(N_REQ_DEF) - 1; i >= 0; i--) begin
         k = IDW_DEF'((int'(ptr) + i) % int'(N_REQ_DEF));
         if (valid[k]) begin
            res.found = 1'b1;
            res.idx   = k;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority encoder: first valid requester at or after i_ptr, wrapping.
// Reusable by any shared-resource arbiter.
module rr_picker
   import dff_share_pkg::*;
#(
   parameter int unsigned N_REQ = N_REQ_DEF,
   parameter int unsigned IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_valid,
   input  logic [IDW-1:0]   i_ptr,
   output logic [N_REQ-1:0] o_onehot,
   output logic [IDW-1:0]   o_idx,
   output logic             o_found
);

   always_comb begin
      logic [IDW-1:0] k;
      k        = '0;
      o_found  = 1'b0;
      o_idx    = '0;
      o_onehot = '0;
      // Highest offset first so the nearest valid requester overwrites the rest.
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         k = IDW'((int'(i_ptr) + i) % int'(N_REQ));
         if (i_valid[k]) begin
            o_found     = 1'b1;
            o_idx       = k;
            o_onehot    = '0;
            o_onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ writers, with bounded
// locking so one requester can hold the register for back-to-back writes.
module dff_share_arbiter
   import dff_share_pkg::*;
#(
   parameter int unsigned N_REQ    = N_REQ_DEF,
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned MAX_LOCK = 8,
   parameter int unsigned IDW      = $clog2(N_REQ)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [N_REQ-1:0]       i_req_valid,
   input  logic [N_REQ-1:0]       i_req_lock,
   input  logic [N_REQ*WIDTH-1:0] i_req_data,
   output logic [N_REQ-1:0]       o_req_ready,
   output logic [WIDTH-1:0]       o_q,
   output logic                   o_q_upd,
   output logic [IDW-1:0]         o_grant_id,
   output logic                   o_locked
);

   localparam int unsigned    CW      = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LOCK);

   arb_state_e       r_state;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_owner;
   logic [CW-1:0]    r_lock_cnt;
   logic [WIDTH-1:0] r_q;
   logic             r_q_upd;
   logic [IDW-1:0]   r_grant_id;

   logic [N_REQ-1:0] w_pick_onehot;
   logic [IDW-1:0]   w_pick_idx;
   logic             w_pick_found;
   logic [N_REQ-1:0] w_ready;
   logic [IDW-1:0]   w_win;
   logic             w_hs;
   logic [WIDTH-1:0] w_win_data;
   logic [WIDTH-1:0] w_slot [N_REQ];

   function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] idx);
      if (idx == IDW'(N_REQ - 1)) return '0;
      return idx + 1'b1;
   endfunction

   for (genvar g = 0; g < int'(N_REQ); g++) begin : g_slot
      assign w_slot[g] = i_req_data[g*WIDTH +: WIDTH];
   end

   rr_picker #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_picker (
      .i_valid  (i_req_valid),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_found  (w_pick_found)
   );

   // While locked only the owner can be granted; everyone else is starved.
   always_comb begin
      w_ready = '0;
      w_win   = w_pick_idx;
      w_hs    = w_pick_found;
      if (r_state == LOCKED) begin
         w_win            = r_owner;
         w_hs             = i_req_valid[r_owner];
         w_ready[r_owner] = i_req_valid[r_owner];
      end else if (w_pick_found) begin
         w_ready = w_pick_onehot;
      end
   end

   assign w_win_data = w_slot[w_win];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_owner    <= '0;
         r_lock_cnt <= '0;
         r_q        <= '0;
         r_q_upd    <= 1'b0;
         r_grant_id <= '0;
      end else begin
         r_q_upd <= w_hs;
         if (w_hs) begin
            r_q        <= w_win_data;
            r_grant_id <= w_win;
         end
         unique case (r_state)
            IDLE: begin
               if (w_hs) begin
                  if (i_req_lock[w_pick_idx]) begin
                     r_state    <= LOCKED;
                     r_owner    <= w_pick_idx;
                     r_lock_cnt <= CW'(1);
                  end else begin
                     r_ptr <= f_next(w_pick_idx);
                  end
               end
            end
            LOCKED: begin
               // Release on voluntary drop or when the hold budget is exhausted.
               if (!i_req_lock[r_owner] || (r_lock_cnt == CNT_MAX)) begin
                  r_state    <= IDLE;
                  r_ptr      <= f_next(r_owner);
                  r_lock_cnt <= '0;
               end else begin
                  r_lock_cnt <= r_lock_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req_ready = w_ready;
   assign o_q         = r_q;
   assign o_q_upd     = r_q_upd;
   assign o_grant_id  = r_grant_id;
   assign o_locked    = (r_state == LOCKED);

endmodule
